// File: rtl/pipeline_control_unit.sv
// pipeline_control_unit
//   Pipelined RV32I control unit. Decodes the Decode-stage instruction,
//   carries the control word through the E, M and W pipeline registers,
//   resolves branches/jumps in Execute from the ALU flags and replaces the
//   wrong-path instruction entering E with a bubble when a redirect is taken.
//
// Parameters
//   EXT_M      : 1 = R-type funct7=0000001 funct3=000 decodes as MUL, 0 = illegal
//   ALU_CTRL_W : width of ALUControl_e (>= 4, upper bits are zero)
//
// Ports
//   clk, rst         : clock, synchronous active-high reset
//   instr_d          : instruction in Decode
//   flush_e          : hazard unit request to load a bubble into E
//   zero_e/lt_e/ltu_e: ALU flags for the E-stage instruction
//   ImmSrc_d         : immediate format (000 I, 001 S, 010 B, 011 J, 100 U)
//   illegal_d        : unsupported opcode/funct combination in Decode
//   ALUControl_e     : ALU operation for the E-stage instruction
//   ALUSrc_e         : 1 = immediate as ALU operand B
//   PCSrc_e          : redirect PC (combinational from E state and flags)
//   PCTargetSrc_e    : 1 = target from ALU result (JALR), 0 = PC+imm
//   ResultSrc_e0     : ResultSrc bit 0 in E (load-use detection)
//   RegWrite_m       : M-stage register write
//   MemWrite_m       : data memory write enable
//   RegWrite_w       : W-stage register write
//   ResultSrc_w      : 00 ALU, 01 memory, 10 PC+4
module pipeline_control_unit #(
   parameter int EXT_M      = 0,
   parameter int ALU_CTRL_W = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           instr_d,
   input  logic                  flush_e,
   input  logic                  zero_e,
   input  logic                  lt_e,
   input  logic                  ltu_e,
   output logic [2:0]            ImmSrc_d,
   output logic                  illegal_d,
   output logic [ALU_CTRL_W-1:0] ALUControl_e,
   output logic                  ALUSrc_e,
   output logic                  PCSrc_e,
   output logic                  PCTargetSrc_e,
   output logic                  ResultSrc_e0,
   output logic                  RegWrite_m,
   output logic                  MemWrite_m,
   output logic                  RegWrite_w,
   output logic [1:0]            ResultSrc_w
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SLT  = 4'b0101;
   localparam logic [3:0] ALU_SLTU = 4'b0110;
   localparam logic [3:0] ALU_SLL  = 4'b0111;
   localparam logic [3:0] ALU_SRL  = 4'b1000;
   localparam logic [3:0] ALU_SRA  = 4'b1001;
   localparam logic [3:0] ALU_PASB = 4'b1010;
   localparam logic [3:0] ALU_MUL  = 4'b1011;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   typedef struct packed {
      logic       reg_write;
      logic [1:0] result_src;
      logic       mem_write;
      logic       jump;
      logic       branch;
      logic [2:0] funct3;
      logic [3:0] alu_ctrl;
      logic       alu_src;
      logic       pc_tgt_src;
   } ctl_t;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       unused_instr;

   assign opcode       = instr_d[6:0];
   assign funct3       = instr_d[14:12];
   assign funct7       = instr_d[31:25];
   assign unused_instr = ^{instr_d[24:15], instr_d[11:7]};

   ctl_t       dec;
   logic [2:0] imm_src;
   logic       illegal;

   ctl_t       e_d, e_q;
   logic       m_reg_write_q, m_mem_write_q, w_reg_write_q;
   logic [1:0] m_result_src_q, w_result_src_q;
   logic       br_cond;

   // Decode stage
   always_comb begin
      dec        = '0;
      imm_src    = IMM_I;
      illegal    = 1'b0;
      dec.funct3 = funct3;
      case (opcode)
         OP_R: begin
            dec.reg_write = 1'b1;
            if (funct7 == 7'b0000001) begin
               if (EXT_M != 0 && funct3 == 3'b000) dec.alu_ctrl = ALU_MUL;
               else                                illegal      = 1'b1;
            end else if (funct7 == 7'b0000000 ||
                         (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
               case (funct3)
                  3'b000:  dec.alu_ctrl = funct7[5] ? ALU_SUB : ALU_ADD;
                  3'b001:  dec.alu_ctrl = ALU_SLL;
                  3'b010:  dec.alu_ctrl = ALU_SLT;
                  3'b011:  dec.alu_ctrl = ALU_SLTU;
                  3'b100:  dec.alu_ctrl = ALU_XOR;
                  3'b101:  dec.alu_ctrl = funct7[5] ? ALU_SRA : ALU_SRL;
                  3'b110:  dec.alu_ctrl = ALU_OR;
                  default: dec.alu_ctrl = ALU_AND;
               endcase
            end else begin
               illegal = 1'b1;
            end
         end
         OP_I: begin
            dec.reg_write = 1'b1;
            dec.alu_src   = 1'b1;
            // Only the shifts use funct7; elsewhere those bits are immediate.
            case (funct3)
               3'b000:  dec.alu_ctrl = ALU_ADD;
               3'b010:  dec.alu_ctrl = ALU_SLT;
               3'b011:  dec.alu_ctrl = ALU_SLTU;
               3'b100:  dec.alu_ctrl = ALU_XOR;
               3'b110:  dec.alu_ctrl = ALU_OR;
               3'b111:  dec.alu_ctrl = ALU_AND;
               3'b001: begin
                  dec.alu_ctrl = ALU_SLL;
                  illegal      = (funct7 != 7'b0000000);
               end
               default: begin
                  dec.alu_ctrl = funct7[5] ? ALU_SRA : ALU_SRL;
                  illegal      = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
               end
            endcase
         end
         OP_LOAD: begin
            dec.reg_write  = 1'b1;
            dec.alu_src    = 1'b1;
            dec.result_src = 2'b01;
            illegal        = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
         end
         OP_STORE: begin
            dec.mem_write = 1'b1;
            dec.alu_src   = 1'b1;
            imm_src       = IMM_S;
            illegal       = (funct3[2] == 1'b1) || (funct3 == 3'b011);
         end
         OP_BRANCH: begin
            dec.branch   = 1'b1;
            dec.alu_ctrl = ALU_SUB;
            imm_src      = IMM_B;
         end
         OP_JAL: begin
            dec.jump       = 1'b1;
            dec.reg_write  = 1'b1;
            dec.result_src = 2'b10;
            imm_src        = IMM_J;
         end
         OP_JALR: begin
            dec.jump       = 1'b1;
            dec.pc_tgt_src = 1'b1;
            dec.alu_src    = 1'b1;
            dec.reg_write  = 1'b1;
            dec.result_src = 2'b10;
            illegal        = (funct3 != 3'b000);
         end
         OP_LUI: begin
            dec.reg_write = 1'b1;
            dec.alu_src   = 1'b1;
            dec.alu_ctrl  = ALU_PASB;
            imm_src       = IMM_U;
         end
         default: illegal = 1'b1;
      endcase
      // Illegal instructions travel as a bubble.
      if (illegal) begin
         dec     = '0;
         imm_src = IMM_I;
      end
   end

   assign ImmSrc_d  = imm_src;
   assign illegal_d = illegal;

   // Execute stage: branch resolution
   always_comb begin
      case (e_q.funct3)
         3'b000:  br_cond = zero_e;
         3'b001:  br_cond = ~zero_e;
         3'b100:  br_cond = lt_e;
         3'b101:  br_cond = ~lt_e;
         3'b110:  br_cond = ltu_e;
         3'b111:  br_cond = ~ltu_e;
         default: br_cond = 1'b0;
      endcase
   end

   assign PCSrc_e = e_q.jump | (e_q.branch & br_cond);

   // A taken redirect discards the instruction currently in Decode.
   assign e_d = (flush_e | PCSrc_e) ? '0 : dec;

   always_ff @(posedge clk) begin
      if (rst) begin
         e_q            <= '0;
         m_reg_write_q  <= 1'b0;
         m_mem_write_q  <= 1'b0;
         m_result_src_q <= 2'b00;
         w_reg_write_q  <= 1'b0;
         w_result_src_q <= 2'b00;
      end else begin
         e_q            <= e_d;
         m_reg_write_q  <= e_q.reg_write;
         m_mem_write_q  <= e_q.mem_write;
         m_result_src_q <= e_q.result_src;
         w_reg_write_q  <= m_reg_write_q;
         w_result_src_q <= m_result_src_q;
      end
   end

   assign ALUControl_e  = ALU_CTRL_W'(e_q.alu_ctrl);
   assign ALUSrc_e      = e_q.alu_src;
   assign PCTargetSrc_e = e_q.pc_tgt_src;
   assign ResultSrc_e0  = e_q.result_src[0];
   assign RegWrite_m    = m_reg_write_q;
   assign MemWrite_m    = m_mem_write_q;
   assign RegWrite_w    = w_reg_write_q;
   assign ResultSrc_w   = w_result_src_q;

endmodule

// File: tb/tb_pipeline_control_unit.sv
module tb_pipeline_control_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] instr_d = 32'h0;
   logic        flush_e = 1'b0, zero_e = 1'b0, lt_e = 1'b0, ltu_e = 1'b0;

   logic [2:0] d0_imm, d1_imm;
   logic       d0_ill, d1_ill;
   logic [3:0] d0_alu;
   logic [4:0] d1_alu;
   logic       d0_asrc, d1_asrc, d0_pcs, d1_pcs, d0_pts, d1_pts, d0_rs0, d1_rs0;
   logic       d0_rwm, d1_rwm, d0_mwm, d1_mwm, d0_rww, d1_rww;
   logic [1:0] d0_rsw, d1_rsw;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   pipeline_control_unit #(.EXT_M(0), .ALU_CTRL_W(4)) dut (
      .clk(clk), .rst(rst), .instr_d(instr_d), .flush_e(flush_e),
      .zero_e(zero_e), .lt_e(lt_e), .ltu_e(ltu_e),
      .ImmSrc_d(d0_imm), .illegal_d(d0_ill), .ALUControl_e(d0_alu),
      .ALUSrc_e(d0_asrc), .PCSrc_e(d0_pcs), .PCTargetSrc_e(d0_pts),
      .ResultSrc_e0(d0_rs0), .RegWrite_m(d0_rwm), .MemWrite_m(d0_mwm),
      .RegWrite_w(d0_rww), .ResultSrc_w(d0_rsw));

   pipeline_control_unit #(.EXT_M(1), .ALU_CTRL_W(5)) dut_m (
      .clk(clk), .rst(rst), .instr_d(instr_d), .flush_e(flush_e),
      .zero_e(zero_e), .lt_e(lt_e), .ltu_e(ltu_e),
      .ImmSrc_d(d1_imm), .illegal_d(d1_ill), .ALUControl_e(d1_alu),
      .ALUSrc_e(d1_asrc), .PCSrc_e(d1_pcs), .PCTargetSrc_e(d1_pts),
      .ResultSrc_e0(d1_rs0), .RegWrite_m(d1_rwm), .MemWrite_m(d1_mwm),
      .RegWrite_w(d1_rww), .ResultSrc_w(d1_rsw));

   // ---------------- behavioural model ----------------
   typedef enum int {
      M_ILL, M_ADD, M_SUB, M_SLL, M_SLT, M_SLTU, M_XOR, M_SRL, M_SRA, M_OR, M_AND, M_MUL,
      M_ADDI, M_SLTI, M_SLTIU, M_XORI, M_ORI, M_ANDI, M_SLLI, M_SRLI, M_SRAI,
      M_LOAD, M_STORE, M_BR, M_JAL, M_JALR, M_LUI
   } mn_t;

   typedef struct packed {
      logic       rw;
      logic [1:0] rs;
      logic       mw;
      logic       jmp;
      logic       br;
      logic [2:0] f3;
      logic [3:0] alu;
      logic       asrc;
      logic       pts;
      logic [2:0] imm;
      logic       ill;
   } mctl_t;

   function automatic mn_t classify(input logic [31:0] ins, input int ext);
      logic [6:0] op = ins[6:0];
      logic [2:0] f3 = ins[14:12];
      logic [6:0] f7 = ins[31:25];
      case (op)
         7'h33: begin
            if (f7 == 7'h00) begin
               case (f3)
                  3'd0: return M_ADD;  3'd1: return M_SLL; 3'd2: return M_SLT; 3'd3: return M_SLTU;
                  3'd4: return M_XOR;  3'd5: return M_SRL; 3'd6: return M_OR;  default: return M_AND;
               endcase
            end
            if (f7 == 7'h20 && f3 == 3'd0) return M_SUB;
            if (f7 == 7'h20 && f3 == 3'd5) return M_SRA;
            if (f7 == 7'h01 && f3 == 3'd0 && ext == 1) return M_MUL;
            return M_ILL;
         end
         7'h13: begin
            case (f3)
               3'd0: return M_ADDI; 3'd2: return M_SLTI; 3'd3: return M_SLTIU;
               3'd4: return M_XORI; 3'd6: return M_ORI;  3'd7: return M_ANDI;
               3'd1: begin
                  if (f7 == 7'h00) return M_SLLI;
                  return M_ILL;
               end
               default: begin
                  if (f7 == 7'h00) return M_SRLI;
                  if (f7 == 7'h20) return M_SRAI;
                  return M_ILL;
               end
            endcase
         end
         7'h03: begin
            if (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) return M_LOAD;
            return M_ILL;
         end
         7'h23: begin
            if (f3 < 3'd3) return M_STORE;
            return M_ILL;
         end
         7'h63: return M_BR;
         7'h6F: return M_JAL;
         7'h67: begin
            if (f3 == 3'd0) return M_JALR;
            return M_ILL;
         end
         7'h37: return M_LUI;
         default: return M_ILL;
      endcase
   endfunction

   function automatic logic [3:0] alu_of(input mn_t m);
      case (m)
         M_SUB, M_BR:    return 4'd1;
         M_AND, M_ANDI:  return 4'd2;
         M_OR, M_ORI:    return 4'd3;
         M_XOR, M_XORI:  return 4'd4;
         M_SLT, M_SLTI:  return 4'd5;
         M_SLTU, M_SLTIU:return 4'd6;
         M_SLL, M_SLLI:  return 4'd7;
         M_SRL, M_SRLI:  return 4'd8;
         M_SRA, M_SRAI:  return 4'd9;
         M_LUI:          return 4'd10;
         M_MUL:          return 4'd11;
         default:        return 4'd0;
      endcase
   endfunction

   function automatic mctl_t ctl_of(input logic [31:0] ins, input int ext);
      mn_t   m = classify(ins, ext);
      mctl_t c = '0;
      logic  is_r = m inside {M_ADD, M_SUB, M_SLL, M_SLT, M_SLTU, M_XOR, M_SRL, M_SRA, M_OR, M_AND, M_MUL};
      logic  is_i = m inside {M_ADDI, M_SLTI, M_SLTIU, M_XORI, M_ORI, M_ANDI, M_SLLI, M_SRLI, M_SRAI};
      if (m == M_ILL) begin
         c.ill = 1'b1;
         return c;
      end
      c.rw   = is_r | is_i | (m inside {M_LOAD, M_JAL, M_JALR, M_LUI});
      c.rs   = (m == M_LOAD) ? 2'b01 : ((m inside {M_JAL, M_JALR}) ? 2'b10 : 2'b00);
      c.mw   = (m == M_STORE);
      c.jmp  = m inside {M_JAL, M_JALR};
      c.br   = (m == M_BR);
      c.f3   = ins[14:12];
      c.alu  = alu_of(m);
      c.asrc = is_i | (m inside {M_LOAD, M_STORE, M_JALR, M_LUI});
      c.pts  = (m == M_JALR);
      c.imm  = (m == M_STORE) ? 3'd1 : (m == M_BR) ? 3'd2 : (m == M_JAL) ? 3'd3 : (m == M_LUI) ? 3'd4 : 3'd0;
      return c;
   endfunction

   // funct3[2:1] picks the flag (zero / lt / ltu), funct3[0] inverts it.
   function automatic logic taken(input mctl_t c, input logic z, input logic l, input logic lu);
      logic flag;
      logic cond;
      flag = c.f3[2] ? (c.f3[1] ? lu : l) : z;
      cond = (c.f3[2:1] == 2'b01) ? 1'b0 : (flag ^ c.f3[0]);
      return c.jmp | (c.br & cond);
   endfunction

   mctl_t pe[2], pm[2], pw[2];
   bit    mvalid = 1'b0;

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            pe[k] = '0; pm[k] = '0; pw[k] = '0;
         end else begin
            logic t;
            t     = taken(pe[k], zero_e, lt_e, ltu_e);
            pw[k] = pm[k];
            pm[k] = pe[k];
            pe[k] = (flush_e || t) ? '0 : ctl_of(instr_d, k);
         end
      end
      if (rst) mvalid = 1'b1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cmp_dut(input int k, input logic [2:0] imm, input logic ill, input logic [4:0] alu,
                          input logic asrc, input logic pcs, input logic pts, input logic rs0,
                          input logic rwm, input logic mwm, input logic rww, input logic [1:0] rsw);
      mctl_t dc = ctl_of(instr_d, k);
      chk($sformatf("ext%0d ImmSrc_d", k),      32'(imm),  32'(dc.imm));
      chk($sformatf("ext%0d illegal_d", k),     32'(ill),  32'(dc.ill));
      chk($sformatf("ext%0d ALUControl_e", k),  32'(alu),  32'(pe[k].alu));
      chk($sformatf("ext%0d ALUSrc_e", k),      32'(asrc), 32'(pe[k].asrc));
      chk($sformatf("ext%0d PCSrc_e", k),       32'(pcs),  32'(taken(pe[k], zero_e, lt_e, ltu_e)));
      chk($sformatf("ext%0d PCTargetSrc_e", k), 32'(pts),  32'(pe[k].pts));
      chk($sformatf("ext%0d ResultSrc_e0", k),  32'(rs0),  32'(pe[k].rs[0]));
      chk($sformatf("ext%0d RegWrite_m", k),    32'(rwm),  32'(pm[k].rw));
      chk($sformatf("ext%0d MemWrite_m", k),    32'(mwm),  32'(pm[k].mw));
      chk($sformatf("ext%0d RegWrite_w", k),    32'(rww),  32'(pw[k].rw));
      chk($sformatf("ext%0d ResultSrc_w", k),   32'(rsw),  32'(pw[k].rs));
   endtask

   // Compare process: every cycle once the model has seen a reset.
   always @(negedge clk) begin
      if (mvalid) begin
         cmp_dut(0, d0_imm, d0_ill, {1'b0, d0_alu}, d0_asrc, d0_pcs, d0_pts, d0_rs0,
                 d0_rwm, d0_mwm, d0_rww, d0_rsw);
         cmp_dut(1, d1_imm, d1_ill, d1_alu, d1_asrc, d1_pcs, d1_pts, d1_rs0,
                 d1_rwm, d1_mwm, d1_rww, d1_rsw);
      end
   end

   // ---------------- stimulus ----------------
   localparam logic [31:0] I_ADD  = 32'h002081B3;
   localparam logic [31:0] I_NOP  = 32'h00000013;
   localparam logic [31:0] I_LW   = 32'h0000A183;
   localparam logic [31:0] I_SW   = 32'h0030A223;
   localparam logic [31:0] I_BEQ  = 32'h00208463;
   localparam logic [31:0] I_BLT  = 32'h0020C463;
   localparam logic [31:0] I_BGEU = 32'h0020F463;
   localparam logic [31:0] I_B010 = 32'h0020A463;
   localparam logic [31:0] I_JALR = 32'h000080E7;
   localparam logic [31:0] I_BAD  = 32'h0000007F;
   localparam logic [31:0] I_MUL  = 32'h022081B3;

   // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
   task automatic drive(input logic [31:0] ins, input logic z = 1'b0, input logic l = 1'b0,
                        input logic lu = 1'b0, input logic fl = 1'b0, input logic r = 1'b0);
      @(posedge clk);
      #1;
      instr_d = ins; zero_e = z; lt_e = l; ltu_e = lu; flush_e = fl; rst = r;
      #1;
   endtask

   initial begin
      logic [31:0] ins, prev;
      logic [31:0] brs[3];
      logic        hold, exp;

      drive(32'h0, 0, 0, 0, 0, 1);
      drive(32'h0, 0, 0, 0, 0, 1);
      // add x3,x1,x2 enters D; E/M/W show reset state
      drive(I_ADD);
      chk("rst RegWrite_m", 32'(d0_rwm), 32'd0);
      chk("rst RegWrite_w", 32'(d0_rww), 32'd0);
      chk("rst MemWrite_m", 32'(d0_mwm), 32'd0);
      chk("rst PCSrc_e",    32'(d0_pcs), 32'd0);
      chk("rst ResultSrc_w", 32'(d0_rsw), 32'd0);
      chk("add illegal_d",  32'(d0_ill), 32'd0);
      drive(I_NOP);
      chk("add ALUControl_e", 32'(d0_alu), 32'd0);
      chk("add ALUSrc_e",     32'(d0_asrc), 32'd0);
      drive(I_LW);
      chk("add RegWrite_m", 32'(d0_rwm), 32'd1);
      drive(I_SW);
      chk("add RegWrite_w",  32'(d0_rww), 32'd1);
      chk("add ResultSrc_w", 32'(d0_rsw), 32'd0);
      chk("lw ResultSrc_e0", 32'(d0_rs0), 32'd1);
      chk("sw ImmSrc_d",     32'(d0_imm), 32'd1);
      drive(I_NOP);
      chk("sw ResultSrc_e0", 32'(d0_rs0), 32'd0);
      chk("lw MemWrite_m",   32'(d0_mwm), 32'd0);
      drive(I_NOP);
      chk("sw MemWrite_m",   32'(d0_mwm), 32'd1);
      chk("lw ResultSrc_w",  32'(d0_rsw), 32'd1);
      drive(I_NOP);
      chk("sw RegWrite_w",   32'(d0_rww), 32'd0);

      // beq taken: following add is discarded
      drive(I_BEQ);
      chk("beq ImmSrc_d", 32'(d0_imm), 32'd2);
      drive(I_ADD, 1);
      chk("beq taken PCSrc_e",       32'(d0_pcs), 32'd1);
      chk("beq taken PCTargetSrc_e", 32'(d0_pts), 32'd0);
      drive(I_NOP, 1, 1, 1);
      chk("bubble PCSrc_e",  32'(d0_pcs), 32'd0);
      chk("bubble ALUSrc_e", 32'(d0_asrc), 32'd0);
      drive(I_NOP);
      chk("bubble RegWrite_m", 32'(d0_rwm), 32'd0);
      chk("addi ALUSrc_e",     32'(d0_asrc), 32'd1);
      // beq not taken: add proceeds
      drive(I_BEQ);
      drive(I_ADD, 0);
      chk("beq not-taken PCSrc_e", 32'(d0_pcs), 32'd0);
      drive(I_NOP);
      chk("add after beq ALUSrc_e", 32'(d0_asrc), 32'd0);
      drive(I_NOP);
      chk("add after beq RegWrite_m", 32'(d0_rwm), 32'd1);

      // jalr: always redirects, target from ALU
      drive(I_JALR);
      drive(I_NOP);
      chk("jalr PCSrc_e",       32'(d0_pcs), 32'd1);
      chk("jalr PCTargetSrc_e", 32'(d0_pts), 32'd1);
      chk("jalr ALUControl_e",  32'(d0_alu), 32'd0);
      drive(I_NOP);
      drive(I_NOP);
      chk("jalr ResultSrc_w", 32'(d0_rsw), 32'd2);
      chk("jalr RegWrite_w",  32'(d0_rww), 32'd1);

      // blt / bgeu / funct3=010 sweep over (lt, ltu)
      brs = '{I_BLT, I_BGEU, I_B010};
      for (int b = 0; b < 3; b++) begin
         for (int c = 0; c < 4; c++) begin
            drive(brs[b]);
            drive(I_NOP, 0, c[1], c[0]);
            exp = (b == 0) ? c[1] : ((b == 1) ? ~c[0] : 1'b0);
            chk($sformatf("branch%0d flags%0d PCSrc_e", b, c), 32'(d0_pcs), 32'(exp));
         end
      end

      // illegal opcode and MUL with / without the M extension
      drive(I_BAD);
      chk("bad illegal_d",   32'(d0_ill), 32'd1);
      chk("bad illegal_d m", 32'(d1_ill), 32'd1);
      drive(I_MUL);
      chk("mul illegal_d ext0", 32'(d0_ill), 32'd1);
      chk("mul illegal_d ext1", 32'(d1_ill), 32'd0);
      drive(I_NOP);
      chk("mul ALUControl_e ext0", 32'(d0_alu), 32'd0);
      chk("mul ALUControl_e ext1", 32'(d1_alu), 32'h0B);
      drive(I_NOP);
      chk("mul RegWrite_m ext0", 32'(d0_rwm), 32'd0);
      chk("mul RegWrite_m ext1", 32'(d1_rwm), 32'd1);
      drive(I_NOP);
      chk("mul RegWrite_w ext0", 32'(d0_rww), 32'd0);

      // reset with a store in M, then with a store in E
      drive(I_SW);
      drive(I_NOP);
      drive(I_NOP, 0, 0, 0, 0, 1);
      chk("sw in M before rst", 32'(d0_mwm), 32'd1);
      drive(I_NOP);
      chk("MemWrite_m after rst", 32'(d0_mwm), 32'd0);
      drive(I_SW);
      drive(I_NOP, 0, 0, 0, 0, 1);
      drive(I_NOP);
      chk("sw in E cleared by rst", 32'(d0_mwm), 32'd0);

      // randomized phase
      prev = I_NOP;
      for (int i = 0; i < 700; i++) begin
         ins = $urandom;
         case ($urandom_range(0, 9))
            0: ins[6:0] = 7'h33;
            1: ins[6:0] = 7'h13;
            2: ins[6:0] = 7'h03;
            3: ins[6:0] = 7'h23;
            4, 5: ins[6:0] = 7'h63;
            6: ins[6:0] = 7'h6F;
            7: ins[6:0] = 7'h67;
            8: ins[6:0] = 7'h37;
            default: ;
         endcase
         case ($urandom_range(0, 4))
            0, 1: ins[31:25] = 7'h00;
            2: ins[31:25] = 7'h20;
            3: ins[31:25] = 7'h01;
            default: ;
         endcase
         if ($urandom_range(0, 3) == 0) ins[14:12] = 3'b000;
         hold = ($urandom_range(0, 7) == 0);
         if (hold) ins = prev;
         drive(ins, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               hold | ($urandom_range(0, 9) == 0), ($urandom_range(0, 49) == 0));
         prev = ins;
      end
      drive(I_NOP);
      @(posedge clk);
      #2;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
